// File: rtl/pixel_loader_pkg.sv
// rtl/pixel_loader_pkg.sv - shared state encoding and width helpers for uart_pixel_loader
package pixel_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int pixels);
        return cnt_w(pixels);
    endfunction

    function automatic int pix_w(input int num_ch, input int ch_bits);
        return num_ch * ch_bits;
    endfunction

endpackage

// File: rtl/uart_pixel_loader_led_stretch.sv
// rtl/uart_pixel_loader_led_stretch.sv - retriggerable activity LED hold timer
module led_stretch #(
    parameter int HOLD_CLKS = 1000000
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Trig,
    output logic o_Led
);

    localparam int CW = pixel_loader_pkg::cnt_w(HOLD_CLKS);

    logic [CW-1:0] cnt_q;
    logic          led_q;

    // LED stays lit for HOLD_CLKS cycles counting the trigger cycle itself.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else if (i_Clear) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else if (i_Trig) begin
            cnt_q <= CW'(HOLD_CLKS - 1);
            led_q <= 1'b1;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end else begin
            led_q <= 1'b0;
        end
    end

    assign o_Led = led_q;

endmodule

// File: rtl/uart_pixel_loader.sv
// rtl/uart_pixel_loader.sv - assembles UART bytes into pixels and writes frame RAM
// Optional frame checksum byte: define PIXEL_LOADER_CHECKSUM_EN.
module uart_pixel_loader
    import pixel_loader_pkg::*;
#(
    parameter int  NUM_CH        = 3,
    parameter int  CH_BITS       = 4,
    parameter int  FRAME_PIXELS  = 19200,
    parameter int  TIMEOUT_CLKS  = 100000,
    parameter int  LED_HOLD_CLKS = 1000000,
    localparam int ADDR_W        = addr_w(FRAME_PIXELS),
    localparam int PIX_W         = pix_w(NUM_CH, CH_BITS)
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Clear,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [PIX_W-1:0]  o_Wr_Data,
    output logic              o_Frame_Done,
    output logic [7:0]        o_Frame_Cnt,
    output logic              o_Busy,
    output logic              o_Err_Timeout,
    output logic              o_Err_Csum,
    output logic              o_Led
);

    localparam int CH_W  = cnt_w(NUM_CH);
    localparam int TMO_W = cnt_w(TIMEOUT_CLKS);
`ifdef PIXEL_LOADER_CHECKSUM_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CH_W-1:0]   ch_q;
    logic [PIX_W-1:0]  pix_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        frame_cnt_q;
    logic              wr_en_q;
    logic              done_q;
    logic              err_tmo_q;

    logic last_px;
    logic csum_byte;
    logic data_byte;
    logic px_full;
    logic tmo_wait;
    logic tmo_fire;
    logic unused_bits;

    assign last_px = (addr_q == ADDR_W'(FRAME_PIXELS - 1));
`ifdef PIXEL_LOADER_CHECKSUM_EN
    // A byte arriving in the last pixel's write cycle is already the checksum.
    assign csum_byte = i_Rx_DV && (state_q == ST_CHECK || (state_q == ST_WRITE && last_px));
`else
    assign csum_byte = 1'b0;
`endif
    assign data_byte = i_Rx_DV && !csum_byte;
    assign px_full   = data_byte && (ch_q == CH_W'(NUM_CH - 1));
    assign tmo_wait  = (state_q == ST_COLLECT || state_q == ST_CHECK) && !i_Rx_DV;
    assign tmo_fire  = tmo_wait && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));
    assign unused_bits = ^i_Rx_Byte;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
            tmo_q       <= '0;
            frame_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else if (i_Clear) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ch_q        <= '0;
            tmo_q       <= '0;
            frame_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= (tmo_wait && !tmo_fire) ? tmo_q + 1'b1 : '0;
            // Shifting channels in from the LSB side leaves channel 0 in the MSBs.
            if (data_byte) begin
                pix_q <= (pix_q << CH_BITS) | PIX_W'(i_Rx_Byte[7 -: CH_BITS]);
                ch_q  <= px_full ? '0 : ch_q + 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (px_full) begin
                        state_q <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else if (data_byte || ch_q != '0) begin
                        state_q <= ST_COLLECT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (px_full) begin
                        state_q <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else if (tmo_fire) begin
                        state_q   <= ST_IDLE;
                        addr_q    <= '0;
                        ch_q      <= '0;
                        err_tmo_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    addr_q <= last_px ? '0 : addr_q + 1'b1;
                    if (last_px) begin
                        if (CHECK_EN && !csum_byte) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end else if (px_full) begin
                        wr_en_q <= 1'b1;
                    end else begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_CHECK: begin
                    if (csum_byte) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end else if (tmo_fire) begin
                        state_q   <= ST_IDLE;
                        addr_q    <= '0;
                        ch_q      <= '0;
                        err_tmo_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PIXEL_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       err_csum_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            csum_q     <= '0;
            err_csum_q <= 1'b0;
        end else if (i_Clear) begin
            csum_q     <= '0;
            err_csum_q <= 1'b0;
        end else begin
            if (data_byte) begin
                csum_q <= (state_q == ST_IDLE || state_q == ST_DONE) ? i_Rx_Byte : csum_q ^ i_Rx_Byte;
            end else if (tmo_fire) begin
                csum_q <= '0;
            end
            if (csum_byte && i_Rx_Byte != csum_q) begin
                err_csum_q <= 1'b1;
            end
        end
    end

    assign o_Err_Csum = err_csum_q;
`else
    assign o_Err_Csum = 1'b0;
`endif

    led_stretch #(
        .HOLD_CLKS (LED_HOLD_CLKS)
    ) u_led (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Clear (i_Clear),
        .i_Trig  (i_Rx_DV),
        .o_Led   (o_Led)
    );

    assign o_Wr_En       = wr_en_q;
    assign o_Wr_Addr     = addr_q;
    assign o_Wr_Data     = pix_q;
    assign o_Frame_Done  = done_q;
    assign o_Frame_Cnt   = frame_cnt_q;
    assign o_Busy        = (state_q != ST_IDLE);
    assign o_Err_Timeout = err_tmo_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb/tb_uart_pixel_loader.sv - self-checking bench for uart_pixel_loader (3 ch x 4 bit, 4-pixel frame)
module tb_uart_pixel_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        busy;
    logic        err_tmo;
    logic        err_csum;
    logic        led;

    int n_pass = 0;
    int n_total = 0;
    int done_seen = 0;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [11:0] exp_data;
    } vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [11:0] data;
    } wr_t;

    wr_t got_q[$];

    always #5 clk = ~clk;

    uart_pixel_loader #(
        .NUM_CH        (3),
        .CH_BITS       (4),
        .FRAME_PIXELS  (4),
        .TIMEOUT_CLKS  (1000),
        .LED_HOLD_CLKS (50)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Clear       (clear),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Wr_En       (wr_en),
        .o_Wr_Addr     (wr_addr),
        .o_Wr_Data     (wr_data),
        .o_Frame_Done  (frame_done),
        .o_Frame_Cnt   (frame_cnt),
        .o_Busy        (busy),
        .o_Err_Timeout (err_tmo),
        .o_Err_Csum    (err_csum),
        .o_Led         (led)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) got_q.push_back(wr_t'{addr: wr_addr, data: wr_data});
            if (frame_done) done_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    function automatic logic [11:0] pix_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {a[7:4], b[7:4], c[7:4]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tab[4];
        logic [7:0] xs;
        logic [7:0] rb;
        logic [7:0] bytes[$];
        logic [7:0] stream[$];
        int         wr0;
        int         np;
        int         db;

        tab[0] = '{8'hF0, 8'h80, 8'h10, 12'hF81};
        tab[1] = '{8'h00, 8'hFF, 8'h7F, 12'h0F7};
        tab[2] = '{8'h12, 8'h34, 8'h56, 12'h135};
        tab[3] = '{8'hAB, 8'hCD, 8'hEF, 12'hACE};

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_err_tmo", err_tmo, 0);
        check("rst_err_csum", err_csum, 0);
        check("rst_led", led, 0);
        rst_n = 1'b1;
        idle(2);

        xs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send(tab[i].b0);
            check("busy_after_ch0", busy, 1);
            idle(2);
            send(tab[i].b1);
            idle(1);
            check("no_early_wr", wr_en, 0);
            send(tab[i].b2);
            check("tab_wr_en", wr_en, 1);
            check("tab_addr", wr_addr, i);
            check("tab_data", wr_data, tab[i].exp_data);
            xs = xs ^ tab[i].b0 ^ tab[i].b1 ^ tab[i].b2;
            if (i < 3) begin
                idle(1);
                check("wr_one_cycle", wr_en, 0);
            end
        end
`ifdef PIXEL_LOADER_CHECKSUM_EN
        send(xs);
`else
        idle(1);
`endif
        check("frame_done", frame_done, 1);
        check("frame_cnt", frame_cnt, 1);
        check("err_csum_ok", err_csum, 0);
        idle(1);
        check("done_one_cycle", frame_done, 0);
        check("idle_after_done", busy, 0);
        send(8'h11); send(8'h22); send(8'h33);
        check("wrap_wr_en", wr_en, 1);
        check("wrap_addr", wr_addr, 0);
        check("wrap_data", wr_data, 12'h123);

        idle(3);
        send(8'h44); idle(1); send(8'h55);
        wr0 = got_q.size();
        idle(999);
        check("tmo_not_yet", err_tmo, 0);
        check("tmo_busy", busy, 1);
        idle(1);
        check("tmo_err", err_tmo, 1);
        check("tmo_idle", busy, 0);
        check("tmo_addr", wr_addr, 0);
        check("tmo_no_write", got_q.size() - wr0, 0);
        send(8'h66); send(8'h77); send(8'h88);
        check("post_tmo_addr", wr_addr, 0);
        check("post_tmo_data", wr_data, 12'h678);

        send(8'h9A); send(8'hBC); send(8'hDE);
        check("pre_clr_addr", wr_addr, 1);
        check("pre_clr_data", wr_data, 12'h9BD);
        send(8'h01); send(8'h23);
        clear = 1'b1;
        send(8'h45);
        clear = 1'b0;
        check("clr_addr", wr_addr, 0);
        check("clr_err_tmo", err_tmo, 0);
        check("clr_cnt", frame_cnt, 0);
        check("clr_busy", busy, 0);
        check("clr_led", led, 0);
        send(8'hF0); send(8'h0F); send(8'hA5);
        check("post_clr_addr", wr_addr, 0);
        check("post_clr_data", wr_data, 12'hF0A);

        send(8'hC3);
        check("led_on", led, 1);
        idle(49);
        check("led_held", led, 1);
        idle(1);
        check("led_off", led, 0);

        for (int r = 0; r < 3; r++) begin
            pulse_clear;
            bytes.delete();
            stream.delete();
            np = $urandom_range(5, 13);
            xs = 8'h00;
            for (int k = 0; k < np * 3; k++) begin
                rb = 8'($urandom);
                bytes.push_back(rb);
                stream.push_back(rb);
                xs = xs ^ rb;
                if (k % 12 == 11) begin
`ifdef PIXEL_LOADER_CHECKSUM_EN
                    stream.push_back(xs);
`endif
                    xs = 8'h00;
                end
            end
            wr0 = got_q.size();
            db = done_seen;
            foreach (stream[s]) begin
                send(stream[s]);
                idle($urandom_range(0, 3));
            end
            idle(6);
            check("rnd_wr_count", got_q.size() - wr0, np);
            for (int k = 0; k < np; k++) begin
                if (wr0 + k < got_q.size()) begin
                    check("rnd_addr", got_q[wr0 + k].addr, k % 4);
                    check("rnd_data", got_q[wr0 + k].data, pix_of(bytes[3*k], bytes[3*k+1], bytes[3*k+2]));
                end
            end
            check("rnd_frame_cnt", frame_cnt, np / 4);
            check("rnd_done_pulses", done_seen - db, np / 4);
            check("rnd_err_tmo", err_tmo, 0);
            check("rnd_err_csum", err_csum, 0);
        end

`ifdef PIXEL_LOADER_CHECKSUM_EN
        pulse_clear;
        xs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send(tab[i].b0); send(tab[i].b1); send(tab[i].b2);
            xs = xs ^ tab[i].b0 ^ tab[i].b1 ^ tab[i].b2;
        end
        send(xs ^ 8'h01);
        check("bad_csum_done", frame_done, 1);
        check("bad_csum_err", err_csum, 1);
        check("bad_csum_cnt", frame_cnt, 1);
`endif

        pulse_clear;
        send(8'hF0); send(8'h80); send(8'h10);
        check("pre_rst_wr_en", wr_en, 1);
        check("pre_rst_data", wr_data, 12'hF81);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_data", wr_data, 0);
        check("arst_busy", busy, 0);
        check("arst_led", led, 0);
        check("arst_done", frame_done, 0);
        #2;
        rst_n = 1'b1;
        idle(2);
        check("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
